// File: rtl/rv32i_regfile_dump_reader_if.sv
// ----------------------------------------------------------------------------
// rv32i_regfile_dump_reader_if
// Beat stream carrying (register index, register value) pairs out of the
// register-file dump reader.
//   valid : beat valid (source -> sink)
//   ready : sink accepts the beat (sink -> source)
//   index : register index of the beat
//   data  : register value of the beat
//   last  : final beat of the dump
// Modports: master = dump reader (source), slave = consumer (sink).
// ----------------------------------------------------------------------------
interface rv32i_regfile_dump_reader_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
);
  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] index;
  logic [XLEN-1:0]  data;
  logic             last;

  modport master (output valid, output index, output data, output last, input ready);
  modport slave  (input valid, input index, input data, input last, output ready);
endinterface

// File: rtl/rv32i_regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// rv32i_regfile_dump_reader
// Walks a contiguous range of RV32I architectural registers through the
// register file's combinational read port and streams each (index, value)
// pair over a valid/ready beat stream. Used by the debug module and the
// simulation trace dumper; read-only, no write port.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-low reset
//   i_start        : one-cycle dump request, accepted only when idle
//   i_first_reg    : first register index (sampled with i_start)
//   i_last_reg     : last register index, inclusive (sampled with i_start)
//   i_abort        : terminate an in-progress dump
//   o_rf_read_reg  : register-file read address
//   i_rf_read_data : register-file combinational read data (x0 reads 0)
//   m_out          : beat stream (master side)
//   o_busy         : registered, high whenever not idle
//   o_done         : one-cycle pulse after the final beat is accepted
//   o_err          : one-cycle pulse when a start request is rejected
// ----------------------------------------------------------------------------
module rv32i_regfile_dump_reader #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int IDX_W     = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic [IDX_W-1:0]                    i_first_reg,
  input  logic [IDX_W-1:0]                    i_last_reg,
  input  logic                                i_abort,
  output logic [IDX_W-1:0]                    o_rf_read_reg,
  input  logic [XLEN-1:0]                     i_rf_read_data,
  rv32i_regfile_dump_reader_if.master         m_out,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDX_W-1:0] r_rf_read_reg;
  logic [IDX_W-1:0] r_last_q;
  logic [IDX_W-1:0] r_out_index;
  logic [XLEN-1:0]  r_out_data;
  logic             r_out_last;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_range_ok;
  logic             w_hs;
  logic             w_is_last;
  logic             w_accept;
  logic             w_reject;
  logic             w_load_beat;
  logic             w_finish;
  logic             w_stop;

  // Only an ordered range is walkable; the upper bound also guards against a
  // register count that does not fill the whole index space.
  assign w_range_ok = (i_first_reg <= i_last_reg) && (i_last_reg <= LAST_IDX);
  assign w_hs       = r_out_valid & m_out.ready;
  // The address being captured is the final one of the dump.
  assign w_is_last  = (r_rf_read_reg == r_last_q);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_load_beat = 1'b0;
    w_finish    = 1'b0;
    w_stop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          if (w_range_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      FETCH: begin
        if (i_abort) begin
          w_stop      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_load_beat = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        // Abort wins; a handshake in the same cycle still counts as delivered.
        if (i_abort) begin
          w_stop      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_hs) begin
          if (r_out_last) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_load_beat = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_rf_read_reg <= '0;
      r_last_q      <= '0;
      r_out_index   <= '0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_finish;
      r_err   <= w_reject;

      if (w_accept) begin
        r_rf_read_reg <= i_first_reg;
        r_last_q      <= i_last_reg;
      end

      // Capture the current read port into the output beat and advance the
      // address; it parks on the last index so it never wraps.
      if (w_load_beat) begin
        r_out_data  <= i_rf_read_data;
        r_out_index <= r_rf_read_reg;
        r_out_last  <= w_is_last;
        r_out_valid <= 1'b1;
        if (!w_is_last) begin
          r_rf_read_reg <= r_rf_read_reg + IDX_W'(1);
        end
      end

      if (w_finish || w_stop) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign o_rf_read_reg = r_rf_read_reg;
  assign m_out.valid   = r_out_valid;
  assign m_out.index   = r_out_index;
  assign m_out.data    = r_out_data;
  assign m_out.last    = r_out_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_rv32i_regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// tb_rv32i_regfile_dump_reader
// Self-checking bench: emulates the register file, drives directed and
// randomized dumps, and compares every delivered beat against an expected
// list built from the register contents over the requested range.
// ----------------------------------------------------------------------------
module tb_rv32i_regfile_dump_reader;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int IDX_W     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] first_reg;
  logic [IDX_W-1:0] last_reg;
  logic             abort;
  logic [IDX_W-1:0] rf_addr;
  logic [XLEN-1:0]  rf_rdata;
  logic             busy;
  logic             done;
  logic             err;

  logic [XLEN-1:0]  rf [REG_COUNT];
  bit               rdy_pat [$];

  int vectors     = 0;
  int miscompares = 0;

  rv32i_regfile_dump_reader_if #(.XLEN(XLEN), .IDX_W(IDX_W)) u_if ();

  rv32i_regfile_dump_reader #(
    .XLEN(XLEN), .REG_COUNT(REG_COUNT), .IDX_W(IDX_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_first_reg    (first_reg),
    .i_last_reg     (last_reg),
    .i_abort        (abort),
    .o_rf_read_reg  (rf_addr),
    .i_rf_read_data (rf_rdata),
    .m_out          (u_if),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, x0 hardwired to zero.
  assign rf_rdata = (rf_addr == '0) ? '0 : rf[rf_addr];

  // Architectural value of register idx.
  function automatic logic [XLEN-1:0] ref_read(input int idx);
    if (idx == 0) return '0;
    return rf[idx];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete dump of [first..last]. ready_pct sets the random ready duty
  // (a non-empty rdy_pat overrides it); abort_idx >= 0 raises abort together
  // with the handshake of that index; poke_start pulses a stray start mid-dump.
  task automatic run_dump(input int first, input int last, input int ready_pct,
                          input int abort_idx, input bit poke_start);
    int               exp_idx [$];
    logic [XLEN-1:0]  exp_dat [$];
    int               n, got, cycles, j;
    bit               aborted, held, r;
    logic [IDX_W-1:0] p_idx;
    logic [XLEN-1:0]  p_dat;
    logic             p_last;

    for (int i = first; i <= last; i++) begin
      exp_idx.push_back(i);
      exp_dat.push_back(ref_read(i));
    end
    n = last - first + 1; got = 0; cycles = 0; aborted = 0; held = 0;
    p_idx = '0; p_dat = '0; p_last = 1'b0;

    @(negedge clk);
    start = 1'b1; first_reg = IDX_W'(first); last_reg = IDX_W'(last); abort = 1'b0;
    @(negedge clk);
    start = 1'b0; first_reg = IDX_W'($urandom); last_reg = IDX_W'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));
    check("valid_in_fetch", 64'(u_if.valid), 64'(0));

    while (got < n && !aborted && cycles < 400) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      check("valid_during_dump", 64'(u_if.valid), 64'(1));
      if (u_if.valid) begin
        if (held) begin
          check("hold_index", 64'(u_if.index), 64'(p_idx));
          check("hold_data", 64'(u_if.data), 64'(p_dat));
          check("hold_last", 64'(u_if.last), 64'(p_last));
        end
        if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
        else                    r = ($urandom_range(99) < ready_pct);
        u_if.ready = r;
        p_idx = u_if.index; p_dat = u_if.data; p_last = u_if.last;
        if (r) begin
          check("beat_index", 64'(u_if.index), 64'(exp_idx[got]));
          check("beat_data", 64'(u_if.data), 64'(exp_dat[got]));
          check("beat_last", 64'(u_if.last), 64'(got == n - 1));
          if (exp_idx[got] == abort_idx) begin
            abort = 1'b1;
            aborted = 1'b1;
          end
          got++;
        end
        held = !r;
        if (poke_start && got == 2) begin
          start = 1'b1; first_reg = IDX_W'($urandom); last_reg = IDX_W'($urandom);
        end
      end
      // Writes to registers outside the range must not disturb the stream.
      j = $urandom_range(REG_COUNT - 1);
      if (j < first || j > last) rf[j] = $urandom;
    end
    if (got < n && !aborted) check("dump_timeout_beats", 64'(got), 64'(n));

    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("done_after_dump", 64'(done), 64'(!aborted));
    check("valid_after_dump", 64'(u_if.valid), 64'(0));
    check("last_after_dump", 64'(u_if.last), 64'(0));
    check("busy_after_dump", 64'(busy), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int cyc, f, l, a;

    rst = 1'b0; start = 1'b0; abort = 1'b0; first_reg = '0; last_reg = '0;
    u_if.ready = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) rf[i] = 32'h1000 + i;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(u_if.valid), 64'(0));
    check("rst_last", 64'(u_if.last), 64'(0));
    check("rst_index", 64'(u_if.index), 64'(0));
    check("rst_data", 64'(u_if.data), 64'(0));
    check("rst_rf_addr", 64'(rf_addr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b1;

    // Full dump with ready held high.
    run_dump(0, 31, 100, -1, 0);
    check("full_rf_addr_parks", 64'(rf_addr), 64'(31));

    // Backpressure with a fixed ready pattern.
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_dump(5, 7, 0, -1, 0);
    check("bp_pattern_used", 64'(rdy_pat.size()), 64'(0));
    rdy_pat.delete();

    // Single register.
    run_dump(31, 31, 100, -1, 0);
    check("single_rf_addr", 64'(rf_addr), 64'(31));

    // Rejected start.
    @(negedge clk);
    start = 1'b1; first_reg = 5'd10; last_reg = 5'd3;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 64'(err), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    check("err_valid", 64'(u_if.valid), 64'(0));
    @(negedge clk);
    check("err_one_cycle", 64'(err), 64'(0));
    check("err_valid_later", 64'(u_if.valid), 64'(0));

    // Abort with the handshake of index 4, then a fresh dump.
    run_dump(0, 31, 100, 4, 0);
    run_dump(20, 23, 100, -1, 0);

    // Start while busy is ignored.
    run_dump(0, 15, 100, -1, 1);

    // Reset mid-dump at index 12.
    @(negedge clk);
    u_if.ready = 1'b1; start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(u_if.valid && u_if.index == 5'd12) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_index_12", 64'(u_if.index), 64'(12));
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(u_if.valid), 64'(0));
    check("mid_rst_last", 64'(u_if.last), 64'(0));
    check("mid_rst_index", 64'(u_if.index), 64'(0));
    check("mid_rst_data", 64'(u_if.data), 64'(0));
    check("mid_rst_rf_addr", 64'(rf_addr), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'(0));

    // Randomized dumps over random register contents.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] = $urandom;
      f = $urandom_range(REG_COUNT - 1);
      l = $urandom_range(REG_COUNT - 1, f);
      a = ($urandom_range(3) == 0) ? $urandom_range(l, f) : -1;
      run_dump(f, l, 60, a, 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
